complex_divider_arbiter: RTL and testbench

- Shares one multi-cycle integer divider among COMPLEX_ISSUE_WIDTH complex-integer lanes.
- Grants a single divider reservation when a div is issued from the complex issue queue.
- Releases the reservation when the div is flushed in register read, or aborted in flight.
- Sequences start, iteration count and result hand-off to writeback.
- Sits between the complex issue queue select logic, the register-read/execute stages and the divider datapath.

---
 rtl/complex_divider_arbiter_pkg.sv | 22 ++
 rtl/complex_divider_arbiter_rr_picker.sv | 30 +++
 rtl/complex_divider_arbiter.sv | 116 +++++++++++
 tb/tb_complex_divider_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/complex_divider_arbiter_pkg.sv
// Shared types and constants for the complex-lane divider arbiter.
package complex_divider_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RESERVED = 2'd1,
    BUSY     = 2'd2,
    DONE     = 2'd3
  } div_arb_state_e;

  localparam int DIV_LATENCY_DEF = 32;
  localparam int LANES_DEF       = 2;
  localparam int LANE_W_DEF      = (LANES_DEF > 1) ? $clog2(LANES_DEF) : 1;

  // Iteration counter width; covers the full DIV_LATENCY range of 2..255.
  localparam int CNT_W = 8;

  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/complex_divider_arbiter_rr_picker.sv
// One-hot round-robin picker: first requesting lane at or after ptr, wrapping.
module div_rr_picker #(
  parameter int LANES  = 2,
  parameter int LANE_W = 1
) (
  input  logic [LANES-1:0]  req,
  input  logic [LANE_W-1:0] ptr,
  output logic [LANES-1:0]  grant,
  output logic [LANE_W-1:0] idx
);

  // Scan lanes starting at ptr and take the first one asking.
  always_comb begin
    int   lane;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    lane  = 0;
    for (int k = 0; k < LANES; k++) begin
      lane = (int'(ptr) + k) % LANES;
      if (!found && req[lane]) begin
        found       = 1'b1;
        grant[lane] = 1'b1;
        idx         = LANE_W'(lane);
      end
    end
  end

endmodule

// File: rtl/complex_divider_arbiter.sv
// Arbitrates one multi-cycle divider among the complex issue lanes:
// reservation at issue, start at execute, cancel/abort on flush, result hand-off.
module complex_divider_arbiter
  import complex_divider_arbiter_pkg::*;
#(
  parameter int LANES       = LANES_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int LANE_W      = lane_width(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [LANES-1:0]  resvReq,
  output logic [LANES-1:0]  resvGrant,
  output logic              divFree,
  input  logic [LANES-1:0]  exValid,
  input  logic [LANES-1:0]  exIsFlushed,
  input  logic              flushInFlight,
  output logic              divStart,
  output logic              divAbort,
  output logic [LANE_W-1:0] busyLane,
  output logic              resultValid,
  input  logic              resultAck
);

  div_arb_state_e    state;
  div_arb_state_e    state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [LANE_W-1:0] rr_ptr;
  logic [LANES-1:0]  pick_grant;
  logic [LANE_W-1:0] pick_idx;
  logic [LANES-1:0]  owner_mask;
  logic              grant_fire;

  div_rr_picker #(
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_picker (
    .req   (resvReq),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign grant_fire  = (state == IDLE) && (|resvReq);
  assign resvGrant   = (state == IDLE) ? pick_grant : '0;
  assign divFree     = (state == IDLE);
  assign resultValid = (state == DONE);
  assign owner_mask  = LANES'(1) << busyLane;

  // Next-state and start/abort pulses; cancel beats start, abort beats expiry.
  always_comb begin
    state_nxt = state;
    divStart  = 1'b0;
    divAbort  = 1'b0;
    case (state)
      IDLE: begin
        if (|resvReq) state_nxt = RESERVED;
      end
      RESERVED: begin
        if (exIsFlushed[busyLane]) begin
          state_nxt = IDLE;
        end else if (exValid[busyLane] && !stall) begin
          divStart  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Leave as the count reaches zero so resultValid lands exactly
        // DIV_LATENCY cycles after the divStart pulse.
        if (flushInFlight) begin
          divAbort  = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (flushInFlight || (resultAck && !stall)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Owner lane, round-robin pointer and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyLane <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      if (grant_fire) begin
        busyLane <= pick_idx;
        rr_ptr   <= (pick_idx == LANE_W'(LANES - 1)) ? '0 : pick_idx + LANE_W'(1);
      end
      if (divStart)            cnt <= CNT_W'(DIV_LATENCY - 1);
      else if (state == BUSY)  cnt <= cnt - CNT_W'(1);
    end
  end

  a_no_req_when_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE) |-> (resvReq == '0));

  a_exvalid_owner_only: assert property (@(posedge clk) disable iff (!rst_n)
    (state == RESERVED) |-> ((exValid & ~owner_mask) == '0));

  a_start_abort_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(divStart && divAbort));

endmodule

// File: tb/tb_complex_divider_arbiter.sv
// Randomized bench for complex_divider_arbiter against a transaction-level model.
module tb_complex_divider_arbiter;

  localparam int LANES = 2;
  localparam int LAT   = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       flushInFlight = 1'b0;
  logic       resultAck = 1'b0;
  logic [1:0] resvReq = '0;
  logic [1:0] exValid = '0;
  logic [1:0] exIsFlushed = '0;
  logic [1:0] resvGrant;
  logic       divFree;
  logic       divStart;
  logic       divAbort;
  logic [0:0] busyLane;
  logic       resultValid;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: reservation held, owner, started-at cycle, next round-robin lane.
  bit m_busy    = 1'b0;
  bit m_started = 1'b0;
  int m_owner   = 0;
  int m_lane    = 0;
  int m_rr      = 0;
  int m_start   = 0;
  int cyc       = 0;

  complex_divider_arbiter #(
    .LANES       (LANES),
    .DIV_LATENCY (LAT),
    .LANE_W      (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .resvReq       (resvReq),
    .resvGrant     (resvGrant),
    .divFree       (divFree),
    .exValid       (exValid),
    .exIsFlushed   (exIsFlushed),
    .flushInFlight (flushInFlight),
    .divStart      (divStart),
    .divAbort      (divAbort),
    .busyLane      (busyLane),
    .resultValid   (resultValid),
    .resultAck     (resultAck)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs against the model, advance the model.
  task automatic step(input logic [1:0] rq, input logic [1:0] ev, input logic [1:0] ef,
                      input logic fi, input logic st, input logic ak);
    int         g;
    int         lane;
    logic [1:0] eg;
    bit         es;
    bit         ea;
    bit         infl;
    bit         done;
    @(negedge clk);
    resvReq = rq; exValid = ev; exIsFlushed = ef;
    flushInFlight = fi; stall = st; resultAck = ak;
    #1;
    g = -1;
    if (!m_busy) begin
      for (int k = 0; k < LANES; k++) begin
        lane = (m_rr + k) % LANES;
        if (g < 0 && rq[lane]) g = lane;
      end
    end
    eg   = (g >= 0) ? (2'b01 << g) : 2'b00;
    infl = m_started && ((cyc - m_start) < LAT);
    done = m_started && ((cyc - m_start) >= LAT);
    es   = m_busy && !m_started && !ef[m_owner] && ev[m_owner] && !st;
    ea   = infl && fi;
    check("resvGrant",   32'(resvGrant),   32'(eg));
    check("divFree",     32'(divFree),     32'(!m_busy));
    check("divStart",    32'(divStart),    32'(es));
    check("divAbort",    32'(divAbort),    32'(ea));
    check("resultValid", 32'(resultValid), 32'(done));
    check("busyLane",    32'(busyLane),    32'(m_lane));
    @(posedge clk);
    if (g >= 0) begin
      m_busy = 1'b1; m_started = 1'b0;
      m_owner = g; m_lane = g; m_rr = (g + 1) % LANES;
    end else if (m_busy && !m_started) begin
      if (ef[m_owner]) m_busy = 1'b0;
      else if (es) begin m_started = 1'b1; m_start = cyc; end
    end else if (infl) begin
      if (fi) begin m_busy = 1'b0; m_started = 1'b0; end
    end else if (done) begin
      if (fi || (ak && !st)) begin m_busy = 1'b0; m_started = 1'b0; end
    end
    cyc++;
  endtask

  initial begin
    logic [1:0] rq;
    logic [1:0] ev;
    logic [1:0] ef;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_divFree",     32'(divFree),     32'd1);
    check("rst_resvGrant",   32'(resvGrant),   32'd0);
    check("rst_resultValid", 32'(resultValid), 32'd0);
    check("rst_busyLane",    32'(busyLane),    32'd0);
    check("rst_divStart",    32'(divStart),    32'd0);
    check("rst_divAbort",    32'(divAbort),    32'd0);

    // Basic lane 0 op: grant, start, then fixed-latency result and ack.
    step(2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (LAT) step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Cancel wins over exValid on the owning lane 1.
    step(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    // Random legal traffic.
    for (int i = 0; i < 4000; i++) begin
      rq = m_busy ? 2'b00 : 2'($urandom_range(0, 3));
      if (m_busy && !m_started)
        ev = ($urandom_range(0, 2) != 0) ? (2'b01 << m_owner) : 2'b00;
      else
        ev = 2'($urandom_range(0, 3));
      ef = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(rq, ev, ef, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
    end

    // Return to idle, start an op on lane 1, then reset asynchronously mid-flight.
    step(2'b00, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (5) step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    check("pre_reset_busyLane", 32'(busyLane), 32'd1);
    @(negedge clk);
    resvReq = '0; exValid = '0; exIsFlushed = '0;
    flushInFlight = 1'b0; stall = 1'b0; resultAck = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_divFree",     32'(divFree),     32'd1);
    check("arst_resultValid", 32'(resultValid), 32'd0);
    check("arst_busyLane",    32'(busyLane),    32'd0);
    check("arst_divAbort",    32'(divAbort),    32'd0);
    check("arst_divStart",    32'(divStart),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 1'b0; m_started = 1'b0; m_owner = 0; m_lane = 0; m_rr = 0; cyc = 0;
    // Round-robin pointer restarts at lane 0.
    step(2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
